// File: rtl/carry_resolve_pkg.sv
// carry_resolve_pkg: shared state encodings and default sizes for the carry resolver
package carry_resolve_pkg;
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 4;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;
endpackage

// File: rtl/carry_step.sv
// carry_step: one carry-propagation iteration, s^(c<<1) and s&(c<<1)
module carry_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] s_next,
    output logic [WIDTH-1:0] c_next,
    output logic             msb_out
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_cell u_half (
            .a(s[i]),
            .b(i == 0 ? 1'b0 : c[(i == 0) ? 0 : i-1]),
            .s(s_next[i]),
            .c(c_next[i])
        );
    end
    assign msb_out = c[WIDTH-1];
endmodule

// File: rtl/half_cell.sv
// half_cell: single-bit half adder
module half_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/carry_resolve_seq.sv
// carry_resolve_seq: sequential adder resolving half-adder sum/carry vectors into a+b
module carry_resolve_seq
    import carry_resolve_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] cout_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic [CNT_W-1:0] iter_count
);
    state_t state, state_nxt;
    logic [WIDTH-1:0] s_q, c_q, s_step, c_step;
    logic [CNT_W-1:0] iter_q;
    logic co_q, msb, accept, step;
    carry_step #(.WIDTH(WIDTH)) u_step (
        .s(s_q),
        .c(c_q),
        .s_next(s_step),
        .c_next(c_step),
        .msb_out(msb)
    );
    always_comb begin
        accept    = (state == ST_IDLE) && in_valid;
        step      = (state == ST_RESOLVE) && (|c_q);
        state_nxt = (state == ST_IDLE)    ? (in_valid ? ST_RESOLVE : ST_IDLE) :
                    (state == ST_RESOLVE) ? ((|c_q) ? ST_RESOLVE : ST_DONE) :
                    (out_ready ? ST_IDLE : ST_DONE);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            c_q    <= '0;
            co_q   <= 1'b0;
            iter_q <= '0;
        end else if (accept) begin
            s_q    <= sum_in;
            c_q    <= cout_in;
            co_q   <= 1'b0;
            iter_q <= '0;
        end else if (step) begin
            s_q    <= s_step;
            c_q    <= c_step;
            co_q   <= co_q | msb;
            iter_q <= iter_q + CNT_W'(1);
        end
    end
    assign in_ready   = state == ST_IDLE;
    assign out_valid  = state == ST_DONE;
    assign result     = s_q;
    assign carry_out  = co_q;
    assign iter_count = iter_q;
endmodule

// File: tb/tb_carry_resolve_seq.sv
// tb_carry_resolve_seq: table-driven and directed checks of the sequential carry resolver
module tb_carry_resolve_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] sum_in = '0;
    logic [7:0] cout_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic       carry_out;
    logic [3:0] iter_count;
    int n_cmp = 0;
    int n_fail = 0;
    typedef struct {
        logic [7:0] s;
        logic [7:0] c;
        logic [7:0] res;
        logic       co;
        logic [3:0] it;
        int         lat;
    } vec_t;
    vec_t tbl[7];
    carry_resolve_seq dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .sum_in(sum_in),
        .cout_in(cout_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .carry_out(carry_out),
        .iter_count(iter_count)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic start(input logic [7:0] s, input logic [7:0] c);
        in_valid = 1'b1;
        sum_in   = s;
        cout_in  = c;
        tick();
        in_valid = 1'b0;
        sum_in   = 8'hxx;
        cout_in  = 8'hxx;
    endtask
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: out_valid never rose, waited %0d cycles", lat);
        end
    endtask
    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask
    initial begin
        int lat;
        tbl[0] = '{8'h06, 8'h01, 8'h08, 1'b0, 4'd3, 4};
        tbl[1] = '{8'hFE, 8'h01, 8'h00, 1'b1, 4'd8, 9};
        tbl[2] = '{8'h33, 8'h00, 8'h33, 1'b0, 4'd0, 1};
        tbl[3] = '{8'h00, 8'h80, 8'h00, 1'b1, 4'd1, 2};
        tbl[4] = '{8'h00, 8'hFF, 8'hFE, 1'b1, 4'd1, 2};
        tbl[5] = '{8'h0F, 8'h0F, 8'h2D, 1'b0, 4'd3, 4};
        tbl[6] = '{8'h00, 8'h00, 8'h00, 1'b0, 4'd0, 1};
        tick();
        tick();
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst result", 32'(result), 32'h0);
        check("rst carry_out", 32'(carry_out), 32'd0);
        check("rst iter_count", 32'(iter_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            start(tbl[i].s, tbl[i].c);
            wait_done(lat);
            check($sformatf("vec%0d result", i), 32'(result), 32'(tbl[i].res));
            check($sformatf("vec%0d carry_out", i), 32'(carry_out), 32'(tbl[i].co));
            check($sformatf("vec%0d iter_count", i), 32'(iter_count), 32'(tbl[i].it));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].lat));
            drain();
        end
        start(8'h06, 8'h01);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            sum_in   = 8'h55;
            cout_in  = 8'h0A;
            tick();
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp in_ready", 32'(in_ready), 32'd0);
            check("bp result", 32'(result), 32'h08);
            check("bp carry_out", 32'(carry_out), 32'd0);
            check("bp iter_count", 32'(iter_count), 32'd3);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp idle in_ready", 32'(in_ready), 32'd1);
        check("bp idle out_valid", 32'(out_valid), 32'd0);
        check("bp idle result held", 32'(result), 32'h08);
        tick();
        in_valid = 1'b0;
        check("bp accepted", 32'(in_ready), 32'd0);
        wait_done(lat);
        check("bp next result", 32'(result), 32'h69);
        check("bp next carry_out", 32'(carry_out), 32'd0);
        check("bp next iter_count", 32'(iter_count), 32'd2);
        check("bp next latency", 32'(lat), 32'd3);
        drain();
        start(8'hFE, 8'h01);
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async rst in_ready", 32'(in_ready), 32'd1);
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst result", 32'(result), 32'h0);
        check("async rst carry_out", 32'(carry_out), 32'd0);
        check("async rst iter_count", 32'(iter_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post rst in_ready", 32'(in_ready), 32'd1);
        start(8'h06, 8'h01);
        wait_done(lat);
        check("post rst result", 32'(result), 32'h08);
        check("post rst carry_out", 32'(carry_out), 32'd0);
        check("post rst iter_count", 32'(iter_count), 32'd3);
        drain();
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] a, b;
            logic [8:0] total;
            a = 8'($urandom);
            b = 8'($urandom);
            total = {1'b0, a} + {1'b0, b};
            start(a ^ b, a & b);
            wait_done(lat);
            check("rand sum", 32'({carry_out, result}), 32'(total));
            n_cmp++;
            if (iter_count > 4'd8) begin
                n_fail++;
                $display("FAIL rand iter_count: got %0d, expected <= 8", iter_count);
            end
            drain();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
